// File: rtl/tile_match_pkg.sv
// Shared types and constants for the tile-matching game engine.
package tile_match_pkg;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        PLAY = 2'd1,
        END  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        CHECK = 2'd3
    } play_t;

    // Wide enough for any colour width; the core takes the low COLOR_W bits.
    localparam logic [31:0] NO_COLOR = 32'hFFFF_FFFF;

endpackage

// File: rtl/tile_pick_enc.sv
// Lowest-index priority encoder over selectable tiles (selected, unmatched, not excluded).
module tile_pick_enc #(
    parameter int N_TILES = 10,
    parameter int IDX_W   = 4
) (
    input  logic [N_TILES-1:0] sel,
    input  logic [N_TILES-1:0] matched,
    input  logic [IDX_W-1:0]   excl_idx,
    input  logic               excl_en,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [N_TILES-1:0] elig;

    genvar gi;
    generate
        for (gi = 0; gi < N_TILES; gi++) begin : g_elig
            assign elig[gi] = sel[gi] & ~matched[gi] & ~(excl_en && (excl_idx == IDX_W'(gi)));
        end
    endgenerate

    // Scan downwards so the lowest eligible index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N_TILES - 1; i >= 0; i--) begin
            if (elig[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tile_match_core.sv
// Tile-matching game engine: mode FSM, pick FSM, reveal timer, score and matched mask.
// Optional miss limit enabled with `define TILE_MISS_LIMIT_EN.
module tile_match_core
    import tile_match_pkg::*;
#(
    parameter int N_TILES    = 10,
    parameter int COLOR_W    = 4,
    parameter int REVEAL_CYC = 100000000,
    parameter int SCORE_W    = 8,
    parameter int MAX_MISSES = 15
) (
    input  logic                       CLOCK_50,
    input  logic                       userquit,
    input  logic                       start,
    input  logic [N_TILES-1:0]         sel,
    input  logic [N_TILES*COLOR_W-1:0] tile_colors,
    output logic [1:0]                 mode,
    output logic [N_TILES-1:0]         shown,
    output logic [N_TILES-1:0]         matched,
    output logic [COLOR_W-1:0]         color_a,
    output logic [COLOR_W-1:0]         color_b,
    output logic [SCORE_W-1:0]         score,
    output logic                       game_won
);

    localparam int IDX_W = $clog2(N_TILES);
    localparam int TMR_W = (REVEAL_CYC > 1) ? $clog2(REVEAL_CYC) : 1;
    localparam logic [COLOR_W-1:0] NONE_C = NO_COLOR[COLOR_W-1:0];

    mode_t              mode_reg, mode_next;
    play_t              play_reg, play_next;
    logic [N_TILES-1:0] matched_reg, matched_next;
    logic [N_TILES-1:0] pick_mask_reg, pick_mask_next;
    logic [IDX_W-1:0]   idx_a_reg, idx_a_next;
    logic [COLOR_W-1:0] color_a_reg, color_a_next;
    logic [COLOR_W-1:0] color_b_reg, color_b_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               armed_reg, armed_next;
    logic [N_TILES-1:0] new_matched;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [COLOR_W-1:0] pick_color;
`ifdef TILE_MISS_LIMIT_EN
    localparam int MISS_W = $clog2(MAX_MISSES + 1);
    logic [MISS_W-1:0]  miss_reg, miss_next, miss_inc;
`endif

    tile_pick_enc #(
        .N_TILES (N_TILES),
        .IDX_W   (IDX_W)
    ) u_pick (
        .sel      (sel),
        .matched  (matched_reg),
        .excl_idx (idx_a_reg),
        .excl_en  (play_reg == ONE),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    assign pick_color = tile_colors[pick_idx*COLOR_W +: COLOR_W];

    always_comb begin
        mode_next      = mode_reg;
        play_next      = play_reg;
        matched_next   = matched_reg;
        pick_mask_next = pick_mask_reg;
        idx_a_next     = idx_a_reg;
        color_a_next   = color_a_reg;
        color_b_next   = color_b_reg;
        timer_next     = timer_reg;
        score_next     = score_reg;
        armed_next     = armed_reg;
        new_matched    = matched_reg;
`ifdef TILE_MISS_LIMIT_EN
        miss_next      = miss_reg;
        miss_inc       = miss_reg + 1'b1;
`endif
        unique case (mode_reg)
            MENU: begin
                if (start) begin
                    mode_next      = PLAY;
                    play_next      = IDLE;
                    matched_next   = '0;
                    pick_mask_next = '0;
                    color_a_next   = NONE_C;
                    color_b_next   = NONE_C;
                    timer_next     = '0;
                    score_next     = '0;
`ifdef TILE_MISS_LIMIT_EN
                    miss_next      = '0;
`endif
                end
            end
            PLAY: begin
                unique case (play_reg)
                    IDLE: begin
                        if (pick_valid) begin
                            idx_a_next     = pick_idx;
                            pick_mask_next = N_TILES'(1) << pick_idx;
                            color_a_next   = pick_color;
                            play_next      = ONE;
                        end
                    end
                    ONE: begin
                        if (pick_valid) begin
                            pick_mask_next = pick_mask_reg | (N_TILES'(1) << pick_idx);
                            color_b_next   = pick_color;
                            timer_next     = '0;
                            play_next      = TWO;
                        end
                    end
                    TWO: begin
                        if (timer_reg == TMR_W'(REVEAL_CYC - 1)) begin
                            timer_next = '0;
                            play_next  = CHECK;
                        end else begin
                            timer_next = timer_reg + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (score_reg != '1) begin
                            score_next = score_reg + 1'b1;
                        end
                        if (color_a_reg == color_b_reg) begin
                            new_matched = matched_reg | pick_mask_reg;
                        end
                        matched_next   = new_matched;
                        pick_mask_next = '0;
                        color_a_next   = NONE_C;
                        color_b_next   = NONE_C;
                        play_next      = IDLE;
                        // Win is judged on the updated mask and beats the miss limit.
                        if (&new_matched) begin
                            mode_next  = END;
                            armed_next = 1'b0;
                        end
`ifdef TILE_MISS_LIMIT_EN
                        else if (color_a_reg != color_b_reg) begin
                            miss_next = miss_inc;
                            if (miss_inc == MISS_W'(MAX_MISSES)) begin
                                mode_next  = END;
                                armed_next = 1'b0;
                            end
                        end
`endif
                    end
                    default: play_next = IDLE;
                endcase
            end
            END: begin
                // start must be seen low once in END before it can return to MENU.
                if (start && armed_reg) begin
                    mode_next = MENU;
                end else if (!start) begin
                    armed_next = 1'b1;
                end
            end
            default: mode_next = MENU;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            mode_reg      <= MENU;
            play_reg      <= IDLE;
            matched_reg   <= '0;
            pick_mask_reg <= '0;
            idx_a_reg     <= '0;
            color_a_reg   <= NONE_C;
            color_b_reg   <= NONE_C;
            timer_reg     <= '0;
            score_reg     <= '0;
            armed_reg     <= 1'b0;
`ifdef TILE_MISS_LIMIT_EN
            miss_reg      <= '0;
`endif
        end else begin
            mode_reg      <= mode_next;
            play_reg      <= play_next;
            matched_reg   <= matched_next;
            pick_mask_reg <= pick_mask_next;
            idx_a_reg     <= idx_a_next;
            color_a_reg   <= color_a_next;
            color_b_reg   <= color_b_next;
            timer_reg     <= timer_next;
            score_reg     <= score_next;
            armed_reg     <= armed_next;
`ifdef TILE_MISS_LIMIT_EN
            miss_reg      <= miss_next;
`endif
        end
    end

    assign mode     = mode_reg;
    assign shown    = matched_reg | pick_mask_reg;
    assign matched  = matched_reg;
    assign color_a  = color_a_reg;
    assign color_b  = color_b_reg;
    assign score    = score_reg;
    assign game_won = (mode_reg == END) && (&matched_reg);

endmodule

// File: tb/tb_tile_match_core.sv
// Bench for tile_match_core: directed game scenarios, then random play, against a pick-queue model.
module tb_tile_match_core;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int RC = 4;
    localparam int SW = 2;
    localparam int MM = 2;

    logic          clk = 1'b0;
    logic          userquit, start;
    logic [N-1:0]  sel;
    logic [N*CW-1:0] tile_colors;
    logic [1:0]    mode;
    logic [N-1:0]  shown, matched;
    logic [CW-1:0] color_a, color_b;
    logic [SW-1:0] score;
    logic          game_won;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tile_match_core #(
        .N_TILES    (N),
        .COLOR_W    (CW),
        .REVEAL_CYC (RC),
        .SCORE_W    (SW),
        .MAX_MISSES (MM)
    ) dut (
        .CLOCK_50    (clk),
        .userquit    (userquit),
        .start       (start),
        .sel         (sel),
        .tile_colors (tile_colors),
        .mode        (mode),
        .shown       (shown),
        .matched     (matched),
        .color_a     (color_a),
        .color_b     (color_b),
        .score       (score),
        .game_won    (game_won)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the game as a list of picked tiles plus a reveal countdown.
    int            m_mode = 0;
    logic [N-1:0]  m_matched = '0;
    int            m_picks[$];
    logic [CW-1:0] m_pcol[$];
    int            m_reveal = 0;
    int            m_score = 0;
    int            m_miss = 0;
    bit            m_armed = 0;
    bit            live = 0;

    always @(posedge clk) begin
        int cand;
        bit hit;
        if (userquit) begin
            m_mode = 0; m_matched = '0; m_picks.delete(); m_pcol.delete();
            m_reveal = 0; m_score = 0; m_miss = 0; m_armed = 0; live = 1;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1; m_matched = '0; m_picks.delete(); m_pcol.delete();
                m_reveal = 0; m_score = 0; m_miss = 0;
            end
        end else if (m_mode == 2) begin
            if (start && m_armed) m_mode = 0;
            else if (!start) m_armed = 1;
        end else if (m_picks.size() < 2) begin
            cand = -1;
            for (int i = N - 1; i >= 0; i--)
                if (sel[i] && !m_matched[i] && !(m_picks.size() == 1 && m_picks[0] == i))
                    cand = i;
            if (cand >= 0) begin
                m_picks.push_back(cand);
                m_pcol.push_back(tile_colors[cand*CW +: CW]);
                if (m_picks.size() == 2) m_reveal = RC;
            end
        end else if (m_reveal > 0) begin
            m_reveal--;
        end else begin
            hit = (m_pcol[0] == m_pcol[1]);
            if (m_score < (1 << SW) - 1) m_score++;
            if (hit) begin
                m_matched[m_picks[0]] = 1'b1;
                m_matched[m_picks[1]] = 1'b1;
            end else begin
                m_miss++;
            end
            $display("pair %0d,%0d colours %0d/%0d %s score=%0d matched=%b",
                     m_picks[0], m_picks[1], m_pcol[0], m_pcol[1],
                     hit ? "hit" : "miss", m_score, m_matched);
            m_picks.delete();
            m_pcol.delete();
            if (m_matched == '1) begin
                m_mode = 2; m_armed = 0;
            end
`ifdef TILE_MISS_LIMIT_EN
            else if (!hit && m_miss >= MM) begin
                m_mode = 2; m_armed = 0;
            end
`endif
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] s;
        if (live) begin
            s = m_matched;
            foreach (m_picks[k]) s[m_picks[k]] = 1'b1;
            check("mode", mode, m_mode);
            check("shown", shown, s);
            check("matched", matched, m_matched);
            check("color_a", color_a, (m_picks.size() >= 1) ? m_pcol[0] : 4'hF);
            check("color_b", color_b, (m_picks.size() == 2) ? m_pcol[1] : 4'hF);
            check("score", score, m_score);
            check("game_won", game_won, (m_mode == 2) && (m_matched == '1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        userquit = 1'b1; start = 1'b0; sel = '0;
        tile_colors = {4'd5, 4'd3, 4'd5, 4'd3};
        cyc(2);
        userquit = 1'b0;
        check("lit_rst_mode", mode, 0);
        check("lit_rst_shown", shown, 0);
        check("lit_rst_color_a", color_a, 4'hF);

        // First game: pick 0 then 2, equal colours.
        start = 1'b1; cyc(1);
        start = 1'b0; sel = 4'b0001; cyc(1);
        check("lit_g1_color_a", color_a, 3);
        sel = 4'b0101; cyc(1);
        check("lit_g1_color_b", color_b, 3);
        check("lit_g1_shown", shown, 4'b0101);
        sel = '0; cyc(5);
        check("lit_g1_matched", matched, 4'b0101);
        check("lit_g1_score", score, 1);

        // Second game: simultaneous select, mismatch, then two matches to win.
        userquit = 1'b1; cyc(1);
        userquit = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0; sel = 4'b0011; cyc(1);
        check("lit_g2_color_a", color_a, 3);
        cyc(1);
        check("lit_g2_color_b", color_b, 5);
        sel = '0; cyc(5);
        check("lit_g2_matched", matched, 0);
        check("lit_g2_shown", shown, 0);
        sel = 4'b0101; cyc(2);
        sel = '0; cyc(5);
        check("lit_g2_m02", matched, 4'b0101);
        sel = 4'b1010; start = 1'b1; cyc(2);
        sel = '0; cyc(4);
        check("lit_g2_prewin_mode", mode, 1);
        cyc(1);
        check("lit_g2_win_mode", mode, 2);
        check("lit_g2_won", game_won, 1);
        check("lit_g2_score", score, 3);
        cyc(2);
        check("lit_g2_held_start", mode, 2);
        start = 1'b0; cyc(1);
        start = 1'b1; cyc(1);
        check("lit_g2_menu", mode, 0);

        // Third game: repeated mismatches on a held switch pair.
        cyc(1);
        check("lit_g3_play", mode, 1);
        start = 1'b0; sel = 4'b0011; cyc(28);
        sel = '0;
`ifdef TILE_MISS_LIMIT_EN
        check("lit_g3_end", mode, 2);
        check("lit_g3_lost", game_won, 0);
        cyc(1);
        start = 1'b1; cyc(1);
        check("lit_g3_menu", mode, 0);
        start = 1'b0;
`else
        check("lit_g3_sat", score, 3);
        check("lit_g3_mode", mode, 1);
`endif

        // Reset in the middle of a reveal.
        userquit = 1'b1; cyc(1);
        userquit = 1'b0; start = 1'b1; cyc(1);
        start = 1'b0; sel = 4'b0011; cyc(2);
        sel = '0; cyc(2);
        userquit = 1'b1; cyc(1);
        userquit = 1'b0;
        check("lit_rq_mode", mode, 0);
        check("lit_rq_shown", shown, 0);
        check("lit_rq_score", score, 0);
        check("lit_rq_color_b", color_b, 4'hF);

        // Random play.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            userquit = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < N; b++) sel[b] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0)
                for (int t = 0; t < N; t++) tile_colors[t*CW +: CW] = CW'($urandom_range(0, 2));
        end
        cyc(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
